// File: rtl/led_matrix_pwm.sv
// ---------------------------------------------------------------------------
// led_matrix_pwm
//
// Row-multiplexed LED matrix driver with per-LED PWM brightness and a
// double-buffered frame store.
//
// Each row dwells BLANK blanking cycles (all rows and columns off), followed by
// (2^BW-1) PWM steps of TICK_DIV cycles each. During the active phase,
// LED (r,c) is lit while front[r][c] > step. Rows scan 0..ROWS-1 cyclically.
//
// The host writes into the back buffer. A swap request is latched and takes
// effect at the next frame start (the first blank cycle of row 0). The write
// and swap decisions are both made on the clock edge that begins that cycle.
// A write on that same edge therefore lands in the buffer that is becoming
// the front buffer, and it is displayed in the new frame.
//
// Ports
//   clk12MHz    : sole clock, rising edge
//   resetn      : asynchronous active-low reset
//   en          : display enable; when low, outputs are off and the scan is
//                 parked in front of row 0
//   wr_en       : back-buffer write strobe
//   wr_row      : back-buffer write row address
//   wr_col      : back-buffer write column address
//   wr_level    : brightness value to store
//   swap_req    : request to exchange the front and back buffers
//   led         : column data, active-low (registered)
//   lcol        : row select, active-low (registered)
//   frame_start : one-cycle pulse on the first blank cycle of row 0
//   swap_ack    : one-cycle pulse in the cycle in which a swap takes effect
// ---------------------------------------------------------------------------
module led_matrix_pwm #(
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int BW       = 4,
    parameter int TICK_DIV = 16,
    parameter int BLANK    = 4,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk12MHz,
    input  logic            resetn,
    input  logic            en,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic [BW-1:0]   wr_level,
    input  logic            swap_req,
    output logic [COLS-1:0] led,
    output logic [ROWS-1:0] lcol,
    output logic            frame_start,
    output logic            swap_ack
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [BW-1:0] PWM_LAST = BW'((1 << BW) - 2);

    // ST_IDLE is the parked state while the display is disabled. Leaving it
    // lands on the first blank cycle of row 0, so frame_start follows en
    // rising by exactly one cycle.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ACTIVE
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [BLW-1:0]  blank_q, blank_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   pwm_q, pwm_d;

    logic            front_sel_q;
    logic            pending_q, pending_d;
    logic            fs_d;
    logic            swap_fire;

    logic [BW-1:0]   frame_mem [2][ROWS][COLS];

    logic [COLS-1:0] led_d;
    logic [ROWS-1:0] lcol_d;
    logic            wr_ok;

    // -----------------------------------------------------------------------
    // Scan sequencer: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        blank_d = blank_q;
        tick_d  = tick_q;
        pwm_d   = pwm_q;

        if (!en) begin
            state_d = ST_IDLE;
            row_d   = '0;
            blank_d = '0;
            tick_d  = '0;
            pwm_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    row_d   = '0;
                    blank_d = '0;
                    tick_d  = '0;
                    pwm_d   = '0;
                end
                ST_BLANK: begin
                    if (blank_q == BLW'(BLANK - 1)) begin
                        state_d = ST_ACTIVE;
                        tick_d  = '0;
                        pwm_d   = '0;
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (tick_q == TW'(TICK_DIV - 1)) begin
                        tick_d = '0;
                        if (pwm_q == PWM_LAST) begin
                            state_d = ST_BLANK;
                            blank_d = '0;
                            pwm_d   = '0;
                            row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                        end else begin
                            pwm_d = pwm_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The upcoming cycle is the first blank cycle of row 0.
    assign fs_d = en && (state_d == ST_BLANK) && (row_d == '0) && (blank_d == '0);

    // A request sampled on the frame-start edge swaps at once; otherwise a
    // previously latched request is honoured there.
    assign swap_fire = fs_d && (pending_q || swap_req);

    always_comb begin
        pending_d = pending_q;
        if (swap_fire) begin
            pending_d = 1'b0;
        end else if (swap_req) begin
            pending_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the next scan state, so the outputs are registered
    // and aligned with the state they describe.
    // -----------------------------------------------------------------------
    always_comb begin
        led_d  = '1;
        lcol_d = '1;
        if (state_d == ST_ACTIVE) begin
            for (int r = 0; r < ROWS; r++) begin
                lcol_d[r] = (row_d != RW'(r));
            end
            // The front buffer is never written and only changes at frame
            // start, so reading it with the current select is safe here.
            for (int c = 0; c < COLS; c++) begin
                led_d[c] = !(frame_mem[front_sel_q][row_d][c] > pwm_d);
            end
        end
    end

    assign wr_ok = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            blank_q     <= '0;
            tick_q      <= '0;
            pwm_q       <= '0;
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
            led         <= '1;
            lcol        <= '1;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            blank_q     <= blank_d;
            tick_q      <= tick_d;
            pwm_q       <= pwm_d;
            pending_q   <= pending_d;
            if (swap_fire) begin
                front_sel_q <= ~front_sel_q;
            end
            led         <= led_d;
            lcol        <= lcol_d;
            frame_start <= fs_d;
            swap_ack    <= swap_fire;
        end
    end

    // -----------------------------------------------------------------------
    // Frame store. The write targets the back buffer as selected before this
    // edge, so a write on the swap edge lands in the new front buffer.
    // -----------------------------------------------------------------------
    // NOTE: the frame store is built from flops and is cleared on reset, so
    // that a reset blanks the picture; this array cannot map to a RAM macro.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        frame_mem[b][r][c] <= '0;
                    end
                end
            end
        end else if (wr_ok) begin
            frame_mem[~front_sel_q][wr_row][wr_col] <= wr_level;
        end
    end

endmodule

// File: tb/tb_led_matrix_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_matrix_pwm
//
// Directed self-checking bench for led_matrix_pwm with default parameters:
// the row dwell is 244 cycles (4 blank cycles and 240 active cycles), and a
// frame is 976 cycles. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_led_matrix_pwm;

    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int DWELL = 244;
    localparam int FRAME = 976;

    logic       clk12MHz;
    logic       resetn;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [2:0] wr_col;
    logic [3:0] wr_level;
    logic       swap_req;
    logic [7:0] led;
    logic [3:0] lcol;
    logic       frame_start;
    logic       swap_ack;

    int checks;
    int failures;

    int on_time [ROWS][COLS];
    int lit_total;
    int bad_scan;
    int fs_cnt;
    int ack_cnt;

    led_matrix_pwm dut (
        .clk12MHz    (clk12MHz),
        .resetn      (resetn),
        .en          (en),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_level    (wr_level),
        .swap_req    (swap_req),
        .led         (led),
        .lcol        (lcol),
        .frame_start (frame_start),
        .swap_ack    (swap_ack)
    );

    initial clk12MHz = 1'b0;
    always #5 clk12MHz = ~clk12MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(negedge clk12MHz);
    endtask

    // Advance until frame_start is seen, bounded by two frames.
    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        check(tag, {31'd0, frame_start}, 32'd1);
    endtask

    task automatic write_cell(input logic [1:0] r, input logic [2:0] c, input logic [3:0] lv);
        wr_en    = 1'b1;
        wr_row   = r;
        wr_col   = c;
        wr_level = lv;
        step();
        wr_en    = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    // Called while sampling the frame_start cycle. Observes one full frame
    // and returns on the sample 976 cycles later, which should be the next
    // frame_start.
    task automatic measure_frame();
        logic [3:0] one;
        logic [3:0] exp_lcol;
        one       = 4'b0001;
        bad_scan  = 0;
        fs_cnt    = 0;
        ack_cnt   = 0;
        lit_total = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                on_time[r][c] = 0;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            exp_lcol = ~(one << r);
            for (int k = 0; k < DWELL; k++) begin
                if (frame_start === 1'b1) fs_cnt++;
                if (swap_ack === 1'b1) ack_cnt++;
                if (k < 4) begin
                    if (lcol !== 4'hF || led !== 8'hFF) bad_scan++;
                end else begin
                    if (lcol !== exp_lcol) bad_scan++;
                    for (int c = 0; c < COLS; c++) begin
                        if (led[c] === 1'b0) begin
                            on_time[r][c]++;
                            lit_total++;
                        end
                    end
                end
                step();
            end
        end
    endtask

    initial begin
        int n_ack;
        int n_fs;
        int n_bad;
        int level [3];

        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        en       = 1'b0;
        wr_en    = 1'b0;
        wr_row   = '0;
        wr_col   = '0;
        wr_level = '0;
        swap_req = 1'b0;
        level[0] = 0;
        level[1] = 7;
        level[2] = 14;

        // ---- Reset state ----------------------------------------------------
        repeat (3) step();
        check("rst_led", {24'd0, led}, 32'hFF);
        check("rst_lcol", {28'd0, lcol}, 32'hF);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        check("rst_ack", {31'd0, swap_ack}, 32'd0);

        // ---- Blank display scan ----------------------------------------------
        en     = 1'b1;
        resetn = 1'b1;
        step();
        check("first_fs", {31'd0, frame_start}, 32'd1);
        check("first_lcol", {28'd0, lcol}, 32'hF);
        measure_frame();
        check("blank_scan_bad", bad_scan, 0);
        check("blank_scan_lit", lit_total, 0);
        check("blank_scan_fs", fs_cnt, 1);
        check("blank_fs_period", {31'd0, frame_start}, 32'd1);

        // ---- Two writes and a swap ----------------------------------------------
        write_cell(2'd0, 3'd0, 4'd15);
        write_cell(2'd1, 3'd3, 4'd1);
        pulse_swap();
        check("no_early_ack", {31'd0, swap_ack}, 32'd0);
        wait_fs("swap_fs");
        check("swap_ack_at_fs", {31'd0, swap_ack}, 32'd1);
        measure_frame();
        check("swap_scan_bad", bad_scan, 0);
        check("on_r0c0_15", on_time[0][0], 240);
        check("on_r1c3_1", on_time[1][3], 16);
        check("swap_lit_total", lit_total, 256);
        check("swap_ack_count", ack_cnt, 1);

        // ---- Level sweep on LED (2,5) --------------------------------------------
        for (int i = 0; i < 3; i++) begin
            write_cell(2'd2, 3'd5, 4'(level[i]));
            pulse_swap();
            wait_fs("sweep_fs");
            check("sweep_ack", {31'd0, swap_ack}, 32'd1);
            measure_frame();
            check("sweep_on_time", on_time[2][5], level[i] * 16);
        end

        // ---- Three requests in one frame, write on the swap edge -----------------
        n_ack = 0;
        for (int i = 1; i < FRAME; i++) begin
            step();
            if (swap_ack === 1'b1) n_ack++;
            swap_req = (i == 10 || i == 20 || i == 30);
            wr_en    = (i == FRAME - 1);
            wr_row   = 2'd3;
            wr_col   = 3'd7;
            wr_level = 4'd9;
        end
        step();
        wr_en = 1'b0;
        check("merge_no_ack_before_fs", n_ack, 0);
        check("merge_fs", {31'd0, frame_start}, 32'd1);
        check("merge_ack", {31'd0, swap_ack}, 32'd1);
        measure_frame();
        check("merge_ack_count", ack_cnt, 1);
        check("swap_edge_write_on", on_time[3][7], 144);
        check("merge_next_fs", {31'd0, frame_start}, 32'd1);
        check("merge_single_swap", {31'd0, swap_ack}, 32'd0);

        // ---- Request on the frame-start edge swaps immediately ------------------
        for (int i = 1; i < FRAME; i++) begin
            step();
            swap_req = (i == FRAME - 1);
        end
        step();
        swap_req = 1'b0;
        check("imm_fs", {31'd0, frame_start}, 32'd1);
        check("imm_ack", {31'd0, swap_ack}, 32'd1);

        // ---- Enable dropped mid-row, then raised ---------------------------------
        repeat (100) step();
        check("en_pre_lcol", {28'd0, lcol}, 32'hE);
        en       = 1'b0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("en_off_lcol", {28'd0, lcol}, 32'hF);
        check("en_off_led", {24'd0, led}, 32'hFF);
        n_ack = 0;
        n_fs  = 0;
        n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en    = (i == 5);
            wr_row   = 2'd3;
            wr_col   = 3'd0;
            wr_level = 4'd5;
            step();
            if (swap_ack === 1'b1) n_ack++;
            if (frame_start === 1'b1) n_fs++;
            if (lcol !== 4'hF || led !== 8'hFF) n_bad++;
        end
        wr_en = 1'b0;
        check("en_off_no_ack", n_ack, 0);
        check("en_off_no_fs", n_fs, 0);
        check("en_off_dark", n_bad, 0);
        en = 1'b1;
        step();
        check("en_on_fs", {31'd0, frame_start}, 32'd1);
        check("en_on_ack", {31'd0, swap_ack}, 32'd1);
        check("en_on_blank", {28'd0, lcol}, 32'hF);
        repeat (3) step();
        check("en_on_blank_end", {28'd0, lcol}, 32'hF);
        step();
        check("en_on_row0", {28'd0, lcol}, 32'hE);

        // ---- Reset mid-frame with a swap pending --------------------------------
        repeat (46) step();
        check("pre_rst_led", {24'd0, led}, 32'hFE);
        pulse_swap();
        repeat (5) step();
        resetn = 1'b0;
        #1;
        check("async_rst_led", {24'd0, led}, 32'hFF);
        check("async_rst_lcol", {28'd0, lcol}, 32'hF);
        check("async_rst_ack", {31'd0, swap_ack}, 32'd0);
        repeat (3) step();
        resetn = 1'b1;
        wait_fs("post_rst_fs");
        check("post_rst_no_ack", {31'd0, swap_ack}, 32'd0);
        measure_frame();
        check("post_rst_bad", bad_scan, 0);
        check("post_rst_front_zero", lit_total, 0);
        check("post_rst_ack_count", ack_cnt, 0);
        pulse_swap();
        wait_fs("post_rst_swap_fs");
        check("post_rst_swap_ack", {31'd0, swap_ack}, 32'd1);
        measure_frame();
        check("post_rst_back_zero", lit_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_pwm.md
LED_MATRIX_PWM -- requirements
Module: led_matrix_pwm

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of multiplexed row-select lines.
REQ-002 SHALL have parameter COLS, default 8, number of LED column-data lines per row.
REQ-003 SHALL have parameter BW, default 4, brightness bits per LED.
REQ-004 SHALL have parameter TICK_DIV, default 16, clock cycles per PWM step (>=1).
REQ-005 SHALL have parameter BLANK, default 4, blanking cycles at the start of each row (>=1).
REQ-006 SHALL have port clk12MHz, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port en, input, 1, display enable.
REQ-009 SHALL have port wr_en, input, 1, back-buffer write strobe.
REQ-010 SHALL have port wr_row, input, clog2(ROWS), write row address.
REQ-011 SHALL have port wr_col, input, clog2(COLS), write column address.
REQ-012 SHALL have port wr_level, input, BW, brightness to store.
REQ-013 SHALL have port swap_req, input, 1, request to exchange front and back buffers.
REQ-014 SHALL have port led, output, COLS, column data, active-low (0 = LED on).
REQ-015 SHALL have port lcol, output, ROWS, row select, active-low (0 = row driven).
REQ-016 SHALL have port frame_start, output, 1, one-cycle pulse on the first blank cycle of row 0.
REQ-017 SHALL have port swap_ack, output, 1, one-cycle pulse when a swap takes effect.

Function
REQ-018 SHALL hold two ROWS x COLS x BW buffers: the front buffer is displayed and the back buffer is written.
REQ-019 SHALL store wr_level at (wr_row, wr_col) of the back buffer on each cycle with wr_en=1; out-of-range addresses SHALL be ignored.
REQ-020 SHALL scan rows 0..ROWS-1 cyclically; each row dwell = BLANK + (2^BW-1)*TICK_DIV cycles.
REQ-021 SHALL, during the blank phase of a row, drive lcol all 1 and led all 1.
REQ-022 SHALL, during the active phase of row r, drive lcol[r]=0 with all other lcol bits 1.
REQ-023 SHALL run a PWM step counter p = 0..2^BW-2 in the active phase, advancing every TICK_DIV cycles.
REQ-024 SHALL drive led[c]=0 iff front[r][c] > p; level 0 is never lit, and level 2^BW-1 is lit for the whole active phase.
REQ-025 SHALL, after row ROWS-1, wrap to row 0 and assert frame_start on the first blank cycle of row 0.
REQ-026 SHALL latch swap_req into a pending flag; repeated requests while pending SHALL merge into one swap.
REQ-027 SHALL perform a pending swap only on the frame_start cycle, and pulse swap_ack on that same cycle.
REQ-028 SHALL apply a write in the swap cycle to the pre-swap back buffer, so that the data is displayed in the new frame.
REQ-029 SHALL, when swap_req arrives in the frame_start cycle with no swap pending, swap immediately in that cycle.
REQ-030 SHALL, when en=0, force lcol and led to all 1, hold the scan at row 0, and zero the blank and PWM counters.
REQ-031 SHALL keep writes and swap_req latching active while en=0, with no swap occurring while en=0.
REQ-032 SHALL, on en rising, begin with the row 0 blank phase, where frame_start pulses and any pending swap occurs.
REQ-033 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-034 SHALL, while resetn=0, set lcol all 1, led all 1, frame_start 0 and swap_ack 0.
REQ-035 SHALL, while resetn=0, clear both buffers to 0, clear swap pending, and set the scan to row 0 with counters at 0.
REQ-036 SHALL, on deassertion of resetn with en=1, start with the row 0 blank phase; a reset in mid-frame SHALL abandon the frame and drop any pending swap.

Verification (defaults: row dwell 244 cycles, frame 976 cycles)
REQ-037 SHALL cover: reset, en=1, no writes -> led=8'hFF throughout; lcol steps 1110,1101,1011,0111 every 244 cycles with a 4-cycle 1111 blank; frame_start every 976 cycles.
REQ-038 SHALL cover: write back[0][0]=15 and back[1][3]=1, then swap_req -> swap_ack on the next frame_start; row 0 led[0]=0 for 240 cycles; row 1 led[3]=0 for 16 cycles, then 1.
REQ-039 SHALL cover: level sweep of 0, 7 and 14 on one LED -> on-time of 0, 112 and 224 cycles per row.
REQ-040 SHALL cover: three swap_req pulses within one frame -> exactly one swap_ack; a write in the swap cycle is visible in that frame.
REQ-041 SHALL cover: en dropped mid-row -> next cycle lcol=1111, led=FF; en raised -> frame_start the next cycle and the row 0 blank phase restarts.
REQ-042 SHALL cover: resetn pulsed low mid-frame with a swap pending -> outputs off immediately, no swap_ack, buffers read 0 after reset.
